// File: rtl/lcd_seq_if.sv
// ----------------------------------------------------------------------------
// Module : lcd_seq_if
// LCD register input and HD44780 pin/status bundle for lcd_seq.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lcd_seq_if;
  logic [31:0] i_lcd_reg;
  logic        o_lcd_on;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic        o_busy;
  logic        o_init_done;
  logic        o_ovf;

  modport master (
    output i_lcd_reg,
    input  o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data,
    input  o_busy, o_init_done, o_ovf
  );

  modport slave (
    input  i_lcd_reg,
    output o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data,
    output o_busy, o_init_done, o_ovf
  );
endinterface

`default_nettype wire

// File: rtl/lcd_seq.sv
// ----------------------------------------------------------------------------
// Module : lcd_seq
// HD44780 write sequencer: power-up init, timed write cycles, 1-deep buffer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lcd_seq #(
  parameter int PWRUP_CYC = 750000,
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 4,
  parameter int SHORT_CYC = 2000,
  parameter int LONG_CYC  = 82000
) (
  input  logic      i_clk,
  input  logic      i_reset,
  lcd_seq_if.slave  if_lcd
);

  localparam int c_MAX_A = (PWRUP_CYC > LONG_CYC) ? PWRUP_CYC : LONG_CYC;
  localparam int c_MAX_B = (SHORT_CYC > EN_CYC) ? SHORT_CYC : EN_CYC;
  localparam int c_MAX_C = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int c_MAX_D = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAX   = (c_MAX_D > c_MAX_C) ? c_MAX_D : c_MAX_C;
  localparam int c_CW    = $clog2(c_MAX + 1);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_PULSE = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_EXEC  = 3'd6;

  function automatic logic [7:0] f_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    f_rom = 8'h38;
      2'd1:    f_rom = 8'h0C;
      2'd2:    f_rom = 8'h01;
      default: f_rom = 8'h06;
    endcase
  endfunction

  logic [2:0]      r_state, w_next;
  logic [c_CW-1:0] r_cnt, w_limit;
  logic            w_tdone;
  logic [1:0]      r_idx;
  logic            r_go_q, w_req;
  logic            r_pend_v, r_pend_rs, w_pend_v_n;
  logic [7:0]      r_pend_data;
  logic            w_load, w_load_rs, w_store, w_drop, w_consume;
  logic [7:0]      w_load_data;
  logic            r_rs, r_long, r_en, r_busy, r_done, r_ovf, r_on;
  logic [7:0]      r_data;
  logic            w_unused_bits;

  assign w_unused_bits = ^{if_lcd.i_lcd_reg[30:11], if_lcd.i_lcd_reg[8]};
  assign w_req         = if_lcd.i_lcd_reg[10] & ~r_go_q;

  always_comb begin
    case (r_state)
      S_PWRUP: w_limit = c_CW'(PWRUP_CYC - 1);
      S_SETUP: w_limit = c_CW'(SETUP_CYC - 1);
      S_PULSE: w_limit = c_CW'(EN_CYC - 1);
      S_HOLD:  w_limit = c_CW'(HOLD_CYC - 1);
      S_EXEC:  w_limit = r_long ? c_CW'(LONG_CYC - 1) : c_CW'(SHORT_CYC - 1);
      default: w_limit = '0;
    endcase
  end
  assign w_tdone = (r_cnt == w_limit);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_PWRUP;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PWRUP: if (w_tdone) w_next = S_INIT;
      S_INIT:  w_next = S_SETUP;
      S_IDLE:  if (r_pend_v || w_req) w_next = S_SETUP;
      S_SETUP: if (w_tdone) w_next = S_PULSE;
      S_PULSE: if (w_tdone) w_next = S_HOLD;
      S_HOLD:  if (w_tdone) w_next = S_EXEC;
      S_EXEC: begin
        if (w_tdone) begin
          if (!r_done && (r_idx != 2'd3)) w_next = S_INIT;
          else if (r_pend_v)              w_next = S_SETUP;
          else                            w_next = S_IDLE;
        end
      end
      default: w_next = S_PWRUP;
    endcase
  end

  // Transfer source selection and request routing into the pending slot
  always_comb begin
    w_load      = (w_next == S_SETUP) && (r_state != S_SETUP);
    w_load_rs   = 1'b0;
    w_load_data = f_rom(r_idx);
    w_consume   = 1'b0;
    w_store     = 1'b0;
    w_drop      = 1'b0;
    if (r_state != S_INIT) begin
      if (r_pend_v) begin
        w_load_rs   = r_pend_rs;
        w_load_data = r_pend_data;
      end else begin
        w_load_rs   = if_lcd.i_lcd_reg[9];
        w_load_data = if_lcd.i_lcd_reg[7:0];
      end
      w_consume = w_load && r_pend_v;
    end
    // In IDLE a request is only buffered when the slot is being drained now.
    if (w_req) begin
      if (r_state == S_IDLE) w_store = r_pend_v;
      else if (r_pend_v)     w_drop  = 1'b1;
      else                   w_store = 1'b1;
    end
    w_pend_v_n = w_store | (r_pend_v & ~w_consume);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_go_q      <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_rs   <= 1'b0;
      r_pend_data <= 8'h00;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_long      <= 1'b0;
      r_en        <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_on        <= 1'b0;
    end else begin
      r_cnt    <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + c_CW'(1);
      r_go_q   <= if_lcd.i_lcd_reg[10];
      r_on     <= if_lcd.i_lcd_reg[31];
      r_pend_v <= w_pend_v_n;
      if (w_store) begin
        r_pend_rs   <= if_lcd.i_lcd_reg[9];
        r_pend_data <= if_lcd.i_lcd_reg[7:0];
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_load) begin
        r_rs   <= w_load_rs;
        r_data <= w_load_data;
        r_long <= ~w_load_rs && (w_load_data inside {8'h01, 8'h02, 8'h03});
      end
      if ((r_state == S_EXEC) && (w_next == S_INIT)) r_idx <= r_idx + 2'd1;
      if ((r_state == S_EXEC) && w_tdone && !r_done && (r_idx == 2'd3)) r_done <= 1'b1;
      r_en   <= (w_next == S_PULSE);
      r_busy <= (w_next != S_IDLE) | w_pend_v_n;
    end
  end

  assign if_lcd.o_lcd_on    = r_on;
  assign if_lcd.o_lcd_en    = r_en;
  assign if_lcd.o_lcd_rs    = r_rs;
  assign if_lcd.o_lcd_rw    = 1'b0;
  assign if_lcd.o_lcd_data  = r_data;
  assign if_lcd.o_busy      = r_busy;
  assign if_lcd.o_init_done = r_done;
  assign if_lcd.o_ovf       = r_ovf;

endmodule

`default_nettype wire
